data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Data-memory slave that answers the core's load/store handshake. It sits directly downstream of the core's `to_mem_o`, `data_mem_addr` and `from_mem_i` ports. It accepts one request at a time, performs byte or word access on an internal word array, and returns a response after a programmable latency. The response is held until the core acknowledges it.

## Interface
Parameters:
- `addr_width_p`, default 10: log2 of the number of 32-bit words stored.
- `latency_p`, default 2: cycles from acceptance to `from_mem_o.valid`. Must be ≥1.

Ports:
- `clk`, input, 1: single clock; all state changes on posedge.
- `reset`, input, 1: reset is asynchronous and active-low.
- `to_mem_i`, input, `mem_in_s`: request from the core.
  - `write_data` [31:0], `valid`, `wen`, `byte_not_word`: request fields.
  - `yumi`: the core's acknowledgement of the response.
- `addr_i`, input, 32: byte address, driven from the core's `data_mem_addr`.
- `from_mem_o`, output, `mem_out_s`: to the core.
  - `yumi`: request accepted.
  - `valid`: response ready.
  - `read_data` [31:0]: response data.

## Operation
- State machine `dmem_state_e`: IDLE, BUSY, RESP.
- **IDLE**
  - `from_mem_o.yumi = to_mem_i.valid`, combinational, same cycle.
  - On accept:
    - latch the request;
    - load the latency counter with `latency_p-1`;
    - go to BUSY, or directly to RESP if `latency_p==1`.
- **BUSY**
  - Counter decrements each cycle; enter RESP when it reaches 0.
  - `yumi` is 0; `to_mem_i.valid` is ignored.
- **RESP**
  - `valid=1` and `read_data` are held stable until `to_mem_i.yumi=1`.
  - On that cycle, return to IDLE.
  - A new request is not accepted in the same cycle as the response yumi; `from_mem_o.yumi` is 0 in RESP.
- **Addressing**
  - Word index = `addr_i[addr_width_p+1:2]`; higher address bits are ignored (wrap-around).
  - Byte lane = `addr_i[1:0]`.
- **Word store:** full 32-bit write at the index; `addr_i[1:0]` is ignored.
- **Byte store:** writes `write_data[7:0]` into the lane only; other lanes are unchanged.
- **Array write timing:** the array is written on the acceptance edge.
- **Word load:** `read_data` = word at the index, sampled on the acceptance edge.
- **Byte load:** `read_data = {24'b0, lane byte}`, zero-extended.
- **Store response:** stores also produce a RESP cycle (the core waits for `valid`), with `read_data = 32'b0`.
- **Core yumi outside RESP:** ignored.
- **Reset**
  - Any state goes to IDLE; counter cleared; latched request cleared.
  - Array contents are NOT reset.
  - A store accepted before reset stays written; a pending response is discarded.

## Timing
- Reset values: `from_mem_o.valid=0`, `from_mem_o.read_data=0`, `from_mem_o.yumi=0` (combinational from IDLE and `valid`).
- Accept at edge T. `valid` rises after edge T+`latency_p-1`, i.e. it is visible during cycle T+`latency_p`.
- Back-to-back: yumi'd response at cycle R. The next request can be accepted at R+1 at the earliest.
- Minimum round trip with `latency_p=1`: accept cycle, response cycle, then next accept. That is 2 cycles per access.
- `read_data` and `valid` are registered outputs. `yumi` is the only combinational output; it depends on state and `to_mem_i.valid` only.
- No combinational path from `to_mem_i.yumi` to any output.

## Structure
- `definitions.sv` already holds `mem_in_s` and `mem_out_s`.
- Add `dmem_state_e` (IDLE/BUSY/RESP) to the same package.
- Sub-module `dmem_array`:
  - `2**addr_width_p` × 32 storage.
  - Synchronous write with a 4-bit byte-enable.
  - Synchronous read.
  - No reset.
- The top level holds the FSM, the latency counter, the byte-enable/lane decode and response formatting.

## Test plan
- Word round trip, `latency_p=2`:
  - Store 0xDEADBEEF to addr 0x10: `yumi` in the same cycle; `valid` 2 cycles later with `read_data=0`.
  - Then load addr 0x10: returns 0xDEADBEEF.
- Byte lanes:
  - Word store 0x11223344 at 0x20, then byte store 0xAA at 0x22.
  - Word load at 0x20 returns 0x11AA3344.
  - Byte load at 0x23 returns 0x00000011.
- Held response: load completes, `to_mem_i.yumi` withheld 5 cycles.
  - `valid` and `read_data` stay constant.
  - `from_mem_o.yumi` stays 0 despite `to_mem_i.valid=1`.
  - Next request is accepted the cycle after the core's yumi.
- Wrap-around, `addr_width_p=4`:
  - Store 0x5 to 0x40, then load 0x00: returns 0x5.
  - Misaligned word load 0x03 also returns 0x5.
- Reset mid-operation:
  - Assert `reset=0` asynchronously while in BUSY.
  - Outputs drop to 0 immediately; no response is produced after release.
  - The earlier store's data is still readable.
- `latency_p=1`, back-to-back loads from the core: accept/response alternate every cycle, with no lost or duplicated responses over 16 requests.

Source files
------------

// File: rtl/definitions.sv
// Shared types for the core's data-memory handshake and the data-memory controller.
package definitions;

    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
    } mem_in_s;

    typedef struct packed {
        logic        yumi;
        logic        valid;
        logic [31:0] read_data;
    } mem_out_s;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } dmem_state_e;

    function automatic logic [3:0] lane_byte_en(input logic byte_not_word, input logic [1:0] lane);
        return byte_not_word ? (4'b0001 << lane) : 4'b1111;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables and a registered read port.
module dmem_array #(
    parameter int addr_width_p = 10
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [3:0]              be,
    input  logic [addr_width_p-1:0] idx,
    input  logic [31:0]             wdata,
    input  logic                    re,
    output logic [31:0]             rdata
);

    logic [31:0] mem [2**addr_width_p];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory slave: accepts one load/store at a time, answers after latency_p cycles
// and holds the response until the core acknowledges it.
module data_mem_ctrl
    import definitions::*;
#(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  mem_in_s     to_mem_i,
    input  logic [31:0] addr_i,
    output mem_out_s    from_mem_o
);

    localparam int CNT_W = (latency_p > 1) ? $clog2(latency_p) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(latency_p - 1);

    dmem_state_e      state_p0, state_n;
    logic [CNT_W-1:0] cnt_p0, cnt_n;
    logic             accept;
    logic [1:0]       lane_p0;
    logic             bnw_p0;
    logic             wen_p0;
    logic [31:0]      array_rdata;
    logic             unused_addr_hi;

    // Address bits above the array depth are deliberately ignored (wrap-around).
    assign unused_addr_hi = ^addr_i[31:addr_width_p+2];

    function automatic logic [31:0] format_resp(input logic wen, input logic bnw,
                                                input logic [1:0] lane, input logic [31:0] word);
        if (wen) return 32'b0;
        if (bnw) return {24'b0, word[8*lane +: 8]};
        return word;
    endfunction

    always_comb begin
        state_n = state_p0;
        cnt_n   = cnt_p0;
        accept  = 1'b0;
        case (state_p0)
            IDLE: begin
                if (to_mem_i.valid) begin
                    accept  = 1'b1;
                    cnt_n   = CNT_LOAD;
                    state_n = (latency_p == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_n = cnt_p0 - CNT_W'(1);
                if (cnt_p0 == CNT_W'(1)) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                if (to_mem_i.yumi) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_p0 <= IDLE;
            cnt_p0   <= '0;
        end else begin
            state_p0 <= state_n;
            cnt_p0   <= cnt_n;
        end
    end

    // Request capture at the acceptance edge; the array access happens on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_p0 <= 2'b0;
            bnw_p0  <= 1'b0;
            wen_p0  <= 1'b0;
        end else if (accept) begin
            lane_p0 <= addr_i[1:0];
            bnw_p0  <= to_mem_i.byte_not_word;
            wen_p0  <= to_mem_i.wen;
        end
    end

    dmem_array #(
        .addr_width_p(addr_width_p)
    ) u_array (
        .clk  (clk),
        .we   (accept & to_mem_i.wen),
        .be   (lane_byte_en(to_mem_i.byte_not_word, addr_i[1:0])),
        .idx  (addr_i[addr_width_p+1:2]),
        .wdata(to_mem_i.byte_not_word ? {4{to_mem_i.write_data[7:0]}} : to_mem_i.write_data),
        .re   (accept & ~to_mem_i.wen),
        .rdata(array_rdata)
    );

    assign from_mem_o.yumi      = accept;
    assign from_mem_o.valid     = (state_p0 == RESP);
    assign from_mem_o.read_data = (state_p0 == RESP) ?
                                  format_resp(wen_p0, bnw_p0, lane_p0, array_rdata) : 32'b0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (latency 2 and latency 1, 16 words each)
// against a cycle-level reference model of the load/store handshake.
module tb_data_mem_ctrl;
    import definitions::*;

    localparam int AW = 4;

    logic        clk = 1'b0;
    logic        rst_n [2];
    mem_in_s     tin   [2];
    logic [31:0] taddr [2];
    mem_out_s    tout  [2];

    always #5 clk = ~clk;

    data_mem_ctrl #(.addr_width_p(AW), .latency_p(2)) dut_a (
        .clk(clk), .reset(rst_n[0]), .to_mem_i(tin[0]), .addr_i(taddr[0]), .from_mem_o(tout[0]));
    data_mem_ctrl #(.addr_width_p(AW), .latency_p(1)) dut_b (
        .clk(clk), .reset(rst_n[1]), .to_mem_i(tin[1]), .addr_i(taddr[1]), .from_mem_o(tout[1]));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: word array per instance plus one outstanding response.
    logic [31:0] mmem [2][16];
    bit          pend [2];
    longint      rdy  [2];
    logic [31:0] edata[2];
    bit          e_yumi [2];
    bit          e_valid[2];
    longint      cyc    = 0;
    bit          chk_en = 0;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic model_accept(input int d);
        int          idx;
        int          lane;
        logic [31:0] w;
        idx  = int'(taddr[d][5:2]);
        lane = int'(taddr[d][1:0]);
        w    = mmem[d][idx];
        if (tin[d].wen) begin
            edata[d] = 32'b0;
            if (tin[d].byte_not_word) w[8*lane +: 8] = tin[d].write_data[7:0];
            else                      w = tin[d].write_data;
            mmem[d][idx] = w;
        end else begin
            edata[d] = tin[d].byte_not_word ? {24'b0, w[8*lane +: 8]} : w;
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n[d]) pend[d] = 0;
            e_valid[d] = pend[d] && (cyc >= rdy[d]);
            e_yumi[d]  = !pend[d] && tin[d].valid;
            if (chk_en) begin
                check($sformatf("yumi_dut%0d", d), 32'(tout[d].yumi), 32'(e_yumi[d]));
                check($sformatf("valid_dut%0d", d), 32'(tout[d].valid), 32'(e_valid[d]));
                if (e_valid[d]) check($sformatf("rdata_dut%0d", d), tout[d].read_data, edata[d]);
            end
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_n[d]) begin
                if (e_valid[d] && tin[d].yumi) begin
                    pend[d] = 0;
                end else if (e_yumi[d]) begin
                    model_accept(d);
                    pend[d] = 1;
                    rdy[d]  = cyc + lat_of(d);
                end
            end
        end
        cyc++;
    end

    task automatic drive_req(input int d, input bit wen, input bit bnw,
                             input logic [31:0] addr, input logic [31:0] wd);
        tin[d].valid         = 1'b1;
        tin[d].wen           = wen;
        tin[d].byte_not_word = bnw;
        tin[d].write_data    = wd;
        taddr[d]             = addr;
    endtask

    task automatic wait_accept(input int d);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tout[d].yumi && n < 40);
        if (!tout[d].yumi) begin
            total++; bad++;
            $display("FAIL accept_timeout dut%0d: got no yumi, expected yumi within 40 cycles", d);
        end
        @(posedge clk); #1;
        tin[d].valid = 1'b0;
    endtask

    task automatic wait_resp(input int d, output logic [31:0] rd, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!tout[d].valid && lat < 40);
        if (!tout[d].valid) begin
            total++; bad++;
            $display("FAIL resp_timeout dut%0d: got no valid, expected valid within 40 cycles", d);
        end
        rd = tout[d].read_data;
    endtask

    task automatic ack(input int d);
        #1 tin[d].yumi = 1'b1;
        @(posedge clk); #1;
        tin[d].yumi = 1'b0;
    endtask

    task automatic access(input int d, input bit wen, input bit bnw, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output int lat);
        drive_req(d, wen, bnw, addr, wd);
        wait_accept(d);
        wait_resp(d, rd, lat);
        ack(d);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] held;
        int          lat;
        int          acc;
        int          rsp;
        int          n;
        bit          took;

        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            tin[d]   = '0;
            taddr[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_valid_dut%0d", d), 32'(tout[d].valid), 32'd0);
            check($sformatf("reset_rdata_dut%0d", d), tout[d].read_data, 32'd0);
            check($sformatf("reset_yumi_dut%0d", d), 32'(tout[d].yumi), 32'd0);
        end
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        chk_en   = 1;

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++)
                access(d, 1, 0, 32'(i * 4), $urandom, rd, lat);

        // word round trip
        access(0, 1, 0, 32'h10, 32'hDEADBEEF, rd, lat);
        check("store_latency", 32'(lat), 32'd2);
        check("store_rdata", rd, 32'h0);
        access(0, 0, 0, 32'h10, 32'h0, rd, lat);
        check("load_word", rd, 32'hDEADBEEF);
        check("load_latency", 32'(lat), 32'd2);

        // byte lanes
        access(0, 1, 0, 32'h20, 32'h11223344, rd, lat);
        access(0, 1, 1, 32'h22, 32'hFFFFFFAA, rd, lat);
        access(0, 0, 0, 32'h20, 32'h0, rd, lat);
        check("byte_merge", rd, 32'h11AA3344);
        access(0, 0, 1, 32'h23, 32'h0, rd, lat);
        check("byte_load_lane3", rd, 32'h00000011);
        access(0, 0, 1, 32'h22, 32'h0, rd, lat);
        check("byte_load_lane2", rd, 32'h000000AA);

        // held response with a competing request waiting
        drive_req(0, 0, 0, 32'h20, 32'h0);
        wait_accept(0);
        drive_req(0, 0, 0, 32'h10, 32'h0);
        wait_resp(0, held, lat);
        check("held_first", held, 32'h11AA3344);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("held_valid", 32'(tout[0].valid), 32'd1);
            check("held_rdata", tout[0].read_data, held);
            check("held_no_yumi", 32'(tout[0].yumi), 32'd0);
        end
        ack(0);
        @(negedge clk);
        check("accept_after_ack", 32'(tout[0].yumi), 32'd1);
        @(posedge clk); #1;
        tin[0].valid = 1'b0;
        wait_resp(0, rd, lat);
        check("queued_load", rd, 32'hDEADBEEF);
        ack(0);

        // wrap-around of the 16-word array
        access(0, 1, 0, 32'h40, 32'h5, rd, lat);
        access(0, 0, 0, 32'h00, 32'h0, rd, lat);
        check("wrap_load", rd, 32'h5);
        access(0, 0, 0, 32'h03, 32'h0, rd, lat);
        check("misaligned_word", rd, 32'h5);

        // asynchronous reset while busy with a store
        drive_req(0, 1, 0, 32'h30, 32'hCAFEF00D);
        wait_accept(0);
        #2 rst_n[0] = 1'b0;
        #1;
        check("async_rst_valid", 32'(tout[0].valid), 32'd0);
        check("async_rst_rdata", tout[0].read_data, 32'd0);
        check("async_rst_yumi", 32'(tout[0].yumi), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_resp_after_rst", 32'(tout[0].valid), 32'd0);
        end
        @(posedge clk); #1;
        access(0, 0, 0, 32'h30, 32'h0, rd, lat);
        check("store_survives_rst", rd, 32'hCAFEF00D);

        // latency 1, back-to-back loads with the core always ready
        acc  = 0;
        rsp  = 0;
        n    = 0;
        drive_req(1, 0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 3)), 32'h0);
        tin[1].yumi = 1'b1;
        while (rsp < 16 && n < 64) begin
            @(negedge clk);
            n++;
            took = tout[1].yumi;
            if (tout[1].yumi) acc++;
            if (tout[1].valid) rsp++;
            @(posedge clk); #1;
            if (took) begin
                if (acc >= 16) tin[1].valid = 1'b0;
                else drive_req(1, 0, 1'($urandom_range(0, 1)),
                               32'(acc * 4 + int'($urandom_range(0, 3))), 32'h0);
            end
        end
        tin[1].yumi  = 1'b0;
        tin[1].valid = 1'b0;
        check("b2b_accepts", 32'(acc), 32'd16);
        check("b2b_responses", 32'(rsp), 32'd16);
        check("b2b_cycles", 32'(n), 32'd32);

        // random traffic on both instances
        for (int c = 0; c < 800; c++) begin
            for (int d = 0; d < 2; d++) begin
                tin[d].valid         = 1'($urandom_range(0, 1));
                tin[d].wen           = 1'($urandom_range(0, 1));
                tin[d].byte_not_word = 1'($urandom_range(0, 1));
                tin[d].write_data    = $urandom;
                tin[d].yumi          = 1'($urandom_range(0, 1));
                taddr[d]             = $urandom;
            end
            @(posedge clk); #1;
        end
        for (int d = 0; d < 2; d++) begin
            tin[d].valid = 1'b0;
            tin[d].yumi  = 1'b1;
        end
        repeat (4) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) tin[d].yumi = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
